// File: rtl/soft_bits_gen.sv
// NCH register-driven soft bits (level / programmable one-shot pulse / toggle) plus constant 0/1.
// Define SOFT_BITS_EDGE_EN to add edge_o, a one-cycle strobe whenever out_o[k] changes.
module soft_bits_gen #(
  parameter int NCH = 4,
  parameter int PW  = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [NCH-1:0]   set_i,
  input  logic [NCH-1:0]   set_wstb_i,
  input  logic [2*NCH-1:0] mode_i,
  input  logic [PW-1:0]    width_i,
  output logic [NCH-1:0]   out_o,
  output logic [NCH-1:0]   busy_o,
`ifdef SOFT_BITS_EDGE_EN
  output logic [NCH-1:0]   edge_o,
`endif
  output logic             zero_o,
  output logic             one_o
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    IDLE_HI = 2'd1,
    PULSE   = 2'd2
  } state_t;

  typedef struct packed {
    state_t        state;
    logic          out;
    logic [PW-1:0] cnt;
  } chan_t;

  localparam logic [1:0] MODE_PULSE  = 2'd1;
  localparam logic [1:0] MODE_TOGGLE = 2'd2;

  // Next-state of one channel; a mode change wins over any strobe in the same cycle.
  function automatic chan_t chan_step(
    input chan_t         cur,
    input logic [1:0]    mode,
    input logic [1:0]    mode_q,
    input logic          wstb,
    input logic          set,
    input logic [PW-1:0] width
  );
    chan_t nxt;
    nxt = cur;
    if (mode != mode_q) begin
      nxt.state = IDLE_LO;
      nxt.out   = 1'b0;
      nxt.cnt   = '0;
    end else begin
      case (mode)
        MODE_PULSE: begin
          if (wstb && set) begin
            nxt.state = PULSE;
            nxt.out   = 1'b1;
            nxt.cnt   = (width == '0) ? '0 : width - PW'(1);
          end else if (wstb) begin
            nxt.state = IDLE_LO;
            nxt.out   = 1'b0;
            nxt.cnt   = '0;
          end else if (cur.state == PULSE) begin
            if (cur.cnt == '0) begin
              nxt.state = IDLE_LO;
              nxt.out   = 1'b0;
            end else begin
              nxt.cnt = cur.cnt - PW'(1);
            end
          end else begin
            nxt = cur;
          end
        end
        MODE_TOGGLE: begin
          nxt.cnt = '0;
          if (wstb && set) begin
            nxt.state = cur.out ? IDLE_LO : IDLE_HI;
            nxt.out   = ~cur.out;
          end else begin
            nxt.state = cur.out ? IDLE_HI : IDLE_LO;
          end
        end
        default: begin
          nxt.cnt = '0;
          if (wstb) begin
            nxt.state = set ? IDLE_HI : IDLE_LO;
            nxt.out   = set;
          end else begin
            nxt.state = cur.out ? IDLE_HI : IDLE_LO;
          end
        end
      endcase
    end
    return nxt;
  endfunction

  logic [1:0] rst_sync_r;
  logic       rst_n_s;

  // Reset asserts asynchronously and releases two clocks after reset_n_i rises.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];
  assign zero_o  = 1'b0;
  assign one_o   = 1'b1;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    chan_t      chan_r;
    chan_t      nxt_s;
    logic [1:0] mode_r;
    logic       busy_r;
`ifdef SOFT_BITS_EDGE_EN
    logic       edge_r;
`endif

    // Channel next-state from the shared step function.
    always_comb begin
      nxt_s = chan_step(chan_r, mode_i[2*k +: 2], mode_r, set_wstb_i[k], set_i[k], width_i);
    end

    // Channel state, stored mode and registered flags.
    always_ff @(posedge clk_i or negedge rst_n_s) begin
      if (!rst_n_s) begin
        chan_r <= '0;
        mode_r <= 2'b00;
        busy_r <= 1'b0;
`ifdef SOFT_BITS_EDGE_EN
        edge_r <= 1'b0;
`endif
      end else begin
        chan_r <= nxt_s;
        mode_r <= mode_i[2*k +: 2];
        busy_r <= (nxt_s.state == PULSE);
`ifdef SOFT_BITS_EDGE_EN
        edge_r <= nxt_s.out ^ chan_r.out;
`endif
      end
    end

    assign out_o[k]  = chan_r.out;
    assign busy_o[k] = busy_r;
`ifdef SOFT_BITS_EDGE_EN
    assign edge_o[k] = edge_r;
`endif
  end

endmodule

// File: tb/tb_soft_bits_gen.sv
// Directed self-checking bench for soft_bits_gen (NCH=4, PW=16).
module tb_soft_bits_gen;
  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [3:0]  set_i;
  logic [3:0]  set_wstb_i;
  logic [7:0]  mode_i;
  logic [15:0] width_i;
  logic [3:0]  out_o;
  logic [3:0]  busy_o;
`ifdef SOFT_BITS_EDGE_EN
  logic [3:0]  edge_o;
`endif
  logic        zero_o;
  logic        one_o;

  int errors = 0;
  int checks = 0;

  soft_bits_gen #(.NCH(4), .PW(16)) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .set_i      (set_i),
    .set_wstb_i (set_wstb_i),
    .mode_i     (mode_i),
    .width_i    (width_i),
    .out_o      (out_o),
    .busy_o     (busy_o),
`ifdef SOFT_BITS_EDGE_EN
    .edge_o     (edge_o),
`endif
    .zero_o     (zero_o),
    .one_o      (one_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic strobe(input logic [3:0] mask, input logic [3:0] val);
    set_i      = val;
    set_wstb_i = mask;
    tick();
    set_wstb_i = 4'b0000;
  endtask

  // Counts further high cycles on channel 0, also checking busy tracks out.
  task automatic count_high(input int start, input int bound, output int total, output bit busy_ok);
    total   = start;
    busy_ok = 1'b1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (busy_o[0] !== out_o[0]) busy_ok = 1'b0;
      if (out_o[0] === 1'b1) total++;
      else break;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_o !== 4'b0000 || busy_o !== 4'b0000) begin
      errors++; $display("FAIL reset_state: out=%b busy=%b want 0000/0000", out_o, busy_o);
    end
    checks++;
    if (zero_o !== 1'b0 || one_o !== 1'b1) begin
      errors++; $display("FAIL const_in_reset: zero=%b one=%b want 0/1", zero_o, one_o);
    end
    repeat (2) tick();
    reset_n_i = 1'b1;
    repeat (3) tick();
    checks++;
    if (out_o !== 4'b0000 || busy_o !== 4'b0000) begin
      errors++; $display("FAIL after_release: out=%b busy=%b want 0000/0000", out_o, busy_o);
    end
  endtask

  task automatic test_level();
    mode_i = 8'h00;
    tick();
    strobe(4'b1111, 4'b1010);
    checks++;
    if (out_o !== 4'b1010 || busy_o !== 4'b0000) begin
      errors++; $display("FAIL level_1010: out=%b busy=%b want 1010/0000", out_o, busy_o);
    end
    checks++;
    if (zero_o !== 1'b0 || one_o !== 1'b1) begin
      errors++; $display("FAIL const_run: zero=%b one=%b want 0/1", zero_o, one_o);
    end
    strobe(4'b0101, 4'b1111);
    checks++;
    if (out_o !== 4'b1111) begin
      errors++; $display("FAIL level_partial: out=%b want 1111", out_o);
    end
    strobe(4'b1111, 4'b0000);
    checks++;
    if (out_o !== 4'b0000) begin
      errors++; $display("FAIL level_clear: out=%b want 0000", out_o);
    end
  endtask

  task automatic run_pulse(input logic [15:0] w, input int want, input string name);
    int  n;
    bit  bok;
    width_i = w;
    strobe(4'b0001, 4'b0001);
    width_i = 16'd20;
    count_high((out_o[0] === 1'b1) ? 1 : 0, want + 8, n, bok);
    checks++;
    if (n != want || !bok) begin
      errors++; $display("FAIL %s: high=%0d busy_ok=%0b want %0d/1", name, n, bok, want);
    end
    checks++;
    if (out_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
      errors++; $display("FAIL %s_end: out=%b busy=%b want 0/0", name, out_o[0], busy_o[0]);
    end
  endtask

  task automatic test_pulse();
    mode_i = 8'h01;
    tick();
    run_pulse(16'd5, 5, "pulse_w5");
    run_pulse(16'd0, 1, "pulse_w0");
    run_pulse(16'd1, 1, "pulse_w1");
    run_pulse(16'd65535, 65535, "pulse_wmax");
  endtask

  task automatic test_retrigger();
    int n;
    bit bok;
    bit gap;
    gap     = 1'b0;
    width_i = 16'd10;
    strobe(4'b0001, 4'b0001);
    n = 1;
    repeat (5) begin
      tick();
      if (out_o[0] === 1'b1) n++;
      else gap = 1'b1;
    end
    strobe(4'b0001, 4'b0001);
    if (out_o[0] === 1'b1) n++;
    else gap = 1'b1;
    count_high(n, 40, n, bok);
    checks++;
    if (n != 16 || gap || !bok) begin
      errors++; $display("FAIL retrigger: high=%0d gap=%0b busy_ok=%0b want 16/0/1", n, gap, bok);
    end
    width_i = 16'd10;
    strobe(4'b0001, 4'b0001);
    repeat (2) tick();
    checks++;
    if (out_o[0] !== 1'b1 || busy_o[0] !== 1'b1) begin
      errors++; $display("FAIL abort_pre: out=%b busy=%b want 1/1", out_o[0], busy_o[0]);
    end
    strobe(4'b0001, 4'b0000);
    checks++;
    if (out_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
      errors++; $display("FAIL abort: out=%b busy=%b want 0/0", out_o[0], busy_o[0]);
    end
  endtask

  task automatic test_toggle();
    logic [2:0] seq;
    mode_i = 8'h02;
    tick();
    strobe(4'b0001, 4'b0001); seq[2] = out_o[0];
    strobe(4'b0001, 4'b0001); seq[1] = out_o[0];
    strobe(4'b0001, 4'b0001); seq[0] = out_o[0];
    checks++;
    if (seq !== 3'b101) begin
      errors++; $display("FAIL toggle_seq: seq=%b want 101", seq);
    end
    strobe(4'b0001, 4'b0000);
    checks++;
    if (out_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
      errors++; $display("FAIL toggle_set0: out=%b busy=%b want 1/0", out_o[0], busy_o[0]);
    end
  endtask

  task automatic test_mode_change();
    mode_i = 8'h00;
    tick();
    strobe(4'b0110, 4'b0110);
    checks++;
    if (out_o !== 4'b0110) begin
      errors++; $display("FAIL mc_setup: out=%b want 0110", out_o);
    end
    // ch1 -> toggle, ch2 -> pulse with strobes ignored; ch3 level strobe honoured.
    mode_i = 8'b00_01_10_00;
    strobe(4'b1110, 4'b1110);
    checks++;
    if (out_o !== 4'b1000 || busy_o !== 4'b0000) begin
      errors++; $display("FAIL mode_change: out=%b busy=%b want 1000/0000", out_o, busy_o);
    end
`ifdef SOFT_BITS_EDGE_EN
    checks++;
    if (edge_o !== 4'b1110) begin
      errors++; $display("FAIL mc_edge: edge=%b want 1110", edge_o);
    end
`endif
    tick();
    checks++;
    if (out_o !== 4'b1000) begin
      errors++; $display("FAIL mc_hold: out=%b want 1000", out_o);
    end
`ifdef SOFT_BITS_EDGE_EN
    checks++;
    if (edge_o !== 4'b0000) begin
      errors++; $display("FAIL mc_edge_once: edge=%b want 0000", edge_o);
    end
`endif
  endtask

  task automatic test_reset_mid_pulse();
    bit stay_low;
    mode_i  = 8'h01;
    tick();
    width_i = 16'd100;
    strobe(4'b0001, 4'b0001);
    repeat (9) tick();
    checks++;
    if (out_o[0] !== 1'b1 || busy_o[0] !== 1'b1) begin
      errors++; $display("FAIL rmp_pre: out=%b busy=%b want 1/1", out_o[0], busy_o[0]);
    end
    #2;
    reset_n_i = 1'b0;
    #1;
    checks++;
    if (out_o !== 4'b0000 || busy_o !== 4'b0000) begin
      errors++; $display("FAIL rmp_async: out=%b busy=%b want 0000/0000", out_o, busy_o);
    end
    checks++;
    if (zero_o !== 1'b0 || one_o !== 1'b1) begin
      errors++; $display("FAIL rmp_const: zero=%b one=%b want 0/1", zero_o, one_o);
    end
    repeat (2) tick();
    reset_n_i = 1'b1;
    stay_low  = 1'b1;
    repeat (10) begin
      tick();
      if (out_o !== 4'b0000 || busy_o !== 4'b0000) stay_low = 1'b0;
    end
    checks++;
    if (!stay_low) begin
      errors++; $display("FAIL rmp_release: out=%b busy=%b want stays 0000", out_o, busy_o);
    end
    strobe(4'b0001, 4'b0001);
    checks++;
    if (out_o[0] !== 1'b1) begin
      errors++; $display("FAIL rmp_restart: out=%b want 1", out_o[0]);
    end
  endtask

  initial begin
    reset_n_i  = 1'b0;
    set_i      = 4'b0000;
    set_wstb_i = 4'b0000;
    mode_i     = 8'h00;
    width_i    = 16'd0;
    test_reset();
    test_level();
    test_pulse();
    test_retrigger();
    test_toggle();
    test_mode_change();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
